// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controller.
// Holds the FSM state encoding, the err_code values, the default frame
// start marker and the frame checksum helper.
package uart_cmd_ctrl_pkg;

   // FSM state encoding. StCsum is only reachable when UART_CMD_CHECKSUM_EN is defined.
   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StAddr  = 3'd1,
      StData  = 3'd2,
      StCsum  = 3'd3,
      StIssue = 3'd4
   } state_e;

   // err_code values, reported on err_code together with err_pulse.
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_OVERRUN = 2'd3;

   // Frame start marker used when the top is not overridden.
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // A frame is consistent when address, data and checksum byte sum to zero mod 256.
   function automatic logic csum_ok(input logic [7:0] addr,
                                    input logic [7:0] data,
                                    input logic [7:0] csum);
      logic [7:0] sum;
      sum = addr + data + csum;
      return sum == 8'h00;
   endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter for the UART command controller.
// Counts enabled cycles since the last clear and flags expiry once the count
// reaches TIMEOUT_CYCLES-1. The count holds at that value until cleared so it
// never wraps back into a non-expired state.
module uart_cmd_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q;

   // Count enabled cycles; clear has priority and the count saturates at CntLast.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
      end else if (enable && (cnt_q != CntLast)) begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   assign expired = enable && (cnt_q == CntLast);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: turns framed UART bytes into register writes.
// Frame: SYNC_BYTE, ADDR, DATA[, CSUM]. The checksum byte and its check are
// built only when the macro UART_CMD_CHECKSUM_EN is defined; otherwise the
// frame is three bytes and DATA goes straight to the write issue state.
// Errors (timeout, checksum, overrun) pulse err_pulse, latch err_code and
// bump a saturating err_count.
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_ready,
   input  logic [7:0] rx_data,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   input  logic       wr_ack,
   output logic       busy,
   output logic       err_pulse,
   output logic [1:0] err_code,
   output logic [7:0] err_count
);

   state_e     state_q;
   logic       rx_prev_q;
   logic [7:0] addr_q;
   logic [7:0] data_q;
   logic       wr_valid_q;
   logic       err_pulse_q;
   logic [1:0] err_code_q;
   logic [7:0] err_count_q;

   logic       accept;
   logic       counting;
   logic       timer_clear;
   logic       expired;
   logic       err_raise;
   logic [1:0] err_kind;

   // One accept per byte: rising edge of the rx_ready level.
   assign accept = rx_ready && !rx_prev_q;

   // The timer runs only while a frame is being collected; outside that it is
   // held at zero so entry to StAddr always starts from a clean count.
   assign counting    = (state_q == StAddr) || (state_q == StData) || (state_q == StCsum);
   assign timer_clear = accept || !counting;

   uart_cmd_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (timer_clear),
      .enable (counting),
      .expired(expired)
   );

   // Decode which error, if any, is reported this cycle; an accepted byte beats a timeout.
   always_comb begin
      err_raise = 1'b0;
      err_kind  = ERR_NONE;
      case (state_q)
         StAddr, StData: begin
            if (!accept && expired) begin
               err_raise = 1'b1;
               err_kind  = ERR_TIMEOUT;
            end
         end
`ifdef UART_CMD_CHECKSUM_EN
         StCsum: begin
            if (accept) begin
               if (!csum_ok(addr_q, data_q, rx_data)) begin
                  err_raise = 1'b1;
                  err_kind  = ERR_CSUM;
               end
            end else if (expired) begin
               err_raise = 1'b1;
               err_kind  = ERR_TIMEOUT;
            end
         end
`endif
         StIssue: begin
            if (accept) begin
               err_raise = 1'b1;
               err_kind  = ERR_OVERRUN;
            end
         end
         default: ;
      endcase
   end

   // Frame FSM with registered outputs and error reporting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rx_prev_q   <= 1'b1;  // a byte already present at reset is not re-accepted
         addr_q      <= '0;
         data_q      <= '0;
         wr_valid_q  <= 1'b0;
         err_pulse_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         err_count_q <= '0;
      end else begin
         rx_prev_q   <= rx_ready;
         err_pulse_q <= 1'b0;

         if (err_raise) begin
            err_pulse_q <= 1'b1;
            err_code_q  <= err_kind;
            if (err_count_q != 8'hFF) begin
               err_count_q <= err_count_q + 8'd1;
            end
         end

         case (state_q)
            StIdle: begin
               if (accept && (rx_data == SYNC_BYTE)) begin
                  state_q <= StAddr;
               end
            end
            StAddr: begin
               if (accept) begin
                  addr_q  <= rx_data;
                  state_q <= StData;
               end else if (expired) begin
                  state_q <= StIdle;
               end
            end
            StData: begin
               if (accept) begin
                  data_q <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                  state_q <= StCsum;
`else
                  wr_valid_q <= 1'b1;
                  state_q    <= StIssue;
`endif
               end else if (expired) begin
                  state_q <= StIdle;
               end
            end
`ifdef UART_CMD_CHECKSUM_EN
            StCsum: begin
               if (accept) begin
                  if (csum_ok(addr_q, data_q, rx_data)) begin
                     wr_valid_q <= 1'b1;
                     state_q    <= StIssue;
                  end else begin
                     state_q <= StIdle;
                  end
               end else if (expired) begin
                  state_q <= StIdle;
               end
            end
`endif
            StIssue: begin
               // Bytes arriving here are dropped (overrun); the write still completes.
               if (wr_ack) begin
                  wr_valid_q <= 1'b0;
                  state_q    <= StIdle;
               end
            end
            default: begin
               wr_valid_q <= 1'b0;
               state_q    <= StIdle;
            end
         endcase
      end
   end

   // addr_q/data_q cannot change while in StIssue, so the write payload is stable.
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = addr_q;
   assign wr_data   = data_q;
   assign busy      = (state_q != StIdle);
   assign err_pulse = err_pulse_q;
   assign err_code  = err_code_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl. Expected writes and errors are pushed
// to queues as frames are driven; a monitor pops and compares them as the DUT
// produces wr_valid/wr_ack handshakes and err_pulse events.
module tb_uart_cmd_ctrl;
   import uart_cmd_ctrl_pkg::*;

   localparam int unsigned TimeoutCycles = 100;
   localparam logic [7:0]  Sync          = DEFAULT_SYNC_BYTE;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ack;
   logic       busy;
   logic       err_pulse;
   logic [1:0] err_code;
   logic [7:0] err_count;

   wr_t         exp_wr_q[$];
   logic [1:0]  exp_err_q[$];
   int unsigned exp_err_total;
   int          n_checks;
   int          n_errors;
   bit          ack_en;

   always #5 clk = ~clk;

   uart_cmd_ctrl #(
      .SYNC_BYTE     (Sync),
      .TIMEOUT_CYCLES(TimeoutCycles)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_ready (rx_ready),
      .rx_data  (rx_data),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ack   (wr_ack),
      .busy     (busy),
      .err_pulse(err_pulse),
      .err_code (err_code),
      .err_count(err_count)
   );

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Downstream acknowledges any pending write while ack_en is set.
   initial begin
      wr_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         wr_ack = ack_en && wr_valid;
      end
   end

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin : monitor
      wr_t w;
      logic [1:0] e;
      if (!rst) begin
         if (wr_valid) begin
            if (exp_wr_q.size() == 0) begin
               check_eq("unexpected_write", 1, 0);
            end else begin
               w = exp_wr_q[0];
               check_eq("wr_addr", wr_addr, w.addr);
               check_eq("wr_data", wr_data, w.data);
               if (wr_ack) void'(exp_wr_q.pop_front());
            end
         end
         if (err_pulse) begin
            if (exp_err_q.size() == 0) begin
               check_eq("unexpected_err", 1, 0);
            end else begin
               e = exp_err_q.pop_front();
               if (exp_err_total < 255) exp_err_total++;
               check_eq("err_code", err_code, e);
               check_eq("err_count", err_count, exp_err_total);
            end
         end
      end
   end

   // Present one byte: rx_ready high for a few cycles, then low for two.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
      send_byte(Sync);
      send_byte(a);
      send_byte(d);
`ifdef UART_CMD_CHECKSUM_EN
      send_byte(c);
`endif
   endtask

   task automatic wait_writes_done(input string tag);
      int n = 0;
      while (exp_wr_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check_eq(tag, exp_wr_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int  n;
      bit  got;
      n_checks      = 0;
      n_errors      = 0;
      exp_err_total = 0;
      ack_en        = 1'b1;
      rst           = 1'b1;
      rx_ready      = 1'b0;
      rx_data       = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_wr_valid", wr_valid, 0);
      check_eq("rst_wr_addr", wr_addr, 0);
      check_eq("rst_wr_data", wr_data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_err_pulse", err_pulse, 0);
      check_eq("rst_err_code", err_code, 0);
      check_eq("rst_err_count", err_count, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Basic frame
      exp_wr_q.push_back('{addr: 8'h12, data: 8'h34});
      send_frame(8'h12, 8'h34, 8'hBA);
      wait_writes_done("basic_write_done");
      @(negedge clk);
      check_eq("basic_busy_idle", busy, 0);
      check_eq("basic_err_count", err_count, 0);
      @(posedge clk);
      #1;

`ifdef UART_CMD_CHECKSUM_EN
      // Bad checksum: error, no write
      exp_err_q.push_back(ERR_CSUM);
      send_frame(8'h12, 8'h34, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      check_eq("csum_err_seen", exp_err_q.size(), 0);
      check_eq("csum_err_code", err_code, ERR_CSUM);
      check_eq("csum_busy", busy, 0);
`else
      // Three-byte frame; the trailing 00 is discarded in idle
      exp_wr_q.push_back('{addr: 8'h12, data: 8'h34});
      send_frame(8'h12, 8'h34, 8'h00);
      send_byte(8'h00);
      wait_writes_done("nocsum_write_done");
      check_eq("nocsum_err_code", err_code, ERR_NONE);
`endif

      // Timeout: error exactly TimeoutCycles after the address byte is accepted
      exp_err_q.push_back(ERR_TIMEOUT);
      send_byte(Sync);
      rx_data  = 8'h12;
      rx_ready = 1'b1;
      @(posedge clk);
      n   = 0;
      got = 1'b0;
      while (n < 300 && !got) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (err_pulse) got = 1'b1;
      end
      check_eq("timeout_latency", n, TimeoutCycles);
      check_eq("timeout_busy", busy, 0);
      check_eq("timeout_code", err_code, ERR_TIMEOUT);
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Overrun while the write waits for wr_ack
      ack_en = 1'b0;
      exp_wr_q.push_back('{addr: 8'h12, data: 8'h34});
      send_frame(8'h12, 8'h34, 8'hBA);
      n = 0;
      while (!wr_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("ovr_wr_valid_up", wr_valid, 1);
      exp_err_q.push_back(ERR_OVERRUN);
      send_byte(8'h55);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_eq("ovr_err_seen", exp_err_q.size(), 0);
      check_eq("ovr_code", err_code, ERR_OVERRUN);
      check_eq("ovr_wr_valid_held", wr_valid, 1);
      check_eq("ovr_wr_addr_held", wr_addr, 8'h12);
      check_eq("ovr_wr_data_held", wr_data, 8'h34);
      @(posedge clk);
      #1;
      ack_en = 1'b1;
      wait_writes_done("ovr_write_done");
      repeat (2) @(posedge clk);
      #1;

      // Leading junk bytes are ignored
      send_byte(8'h00);
      send_byte(8'hFF);
      exp_wr_q.push_back('{addr: 8'h01, data: 8'h02});
      send_frame(8'h01, 8'h02, 8'hFD);
      wait_writes_done("junk_write_done");
      repeat (2) @(posedge clk);
      #1;

      // Reset mid-frame with the SYNC byte still present on the receiver
      rx_data  = Sync;
      rx_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("midrst_busy_before", busy, 1);
      @(posedge clk);
      #1;
      rst           = 1'b1;
      exp_err_total = 0;
      @(posedge clk);
      @(negedge clk);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_wr_valid", wr_valid, 0);
      check_eq("midrst_wr_addr", wr_addr, 0);
      check_eq("midrst_wr_data", wr_data, 0);
      check_eq("midrst_err_code", err_code, 0);
      check_eq("midrst_err_count", err_count, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("midrst_no_reaccept", busy, 0);
      rx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'hBA);
      check_eq("midrst_idle_after", busy, 0);

      // rx_ready held high for 50 cycles on one byte gives a single accept
      rx_data  = Sync;
      rx_ready = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      rx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_wr_q.push_back('{addr: 8'h12, data: 8'h34});
      send_byte(8'h12);
      send_byte(8'h34);
`ifdef UART_CMD_CHECKSUM_EN
      send_byte(8'hBA);
`endif
      wait_writes_done("hold_write_done");

      repeat (10) @(posedge clk);
      #1;
      check_eq("end_wr_queue_empty", exp_wr_q.size(), 0);
      check_eq("end_err_queue_empty", exp_err_q.size(), 0);
      check_eq("end_err_count", err_count, exp_err_total);
      check_eq("end_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter TIMEOUT_CYCLES, default 2500000, max clk cycles between accepted bytes inside a frame.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rx_ready  in  1  receiver byte-valid level; goes high after a stop bit and stays high until the next start bit.
REQ-006 rx_data  in  8  received byte; stable while rx_ready is high.
REQ-007 wr_valid  out  1  register-write request.
REQ-008 wr_addr  out  8  write address.
REQ-009 wr_data  out  8  write data.
REQ-010 wr_ack  in  1  downstream accepts the write in a cycle where wr_valid=1.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 err_pulse  out  1  one-cycle pulse on any frame error.
REQ-013 err_code  out  2  last error: 0 none, 1 timeout, 2 checksum, 3 overrun.
REQ-014 err_count  out  8  saturating error counter.

Function
REQ-015 A byte is accepted on the rising edge of rx_ready (registered previous value 0, current 1): one accept per received byte, latency 1 cycle.
REQ-016 States: IDLE, ADDR, DATA, CSUM, ISSUE.
REQ-017 IDLE: an accepted byte equal to SYNC_BYTE moves to ADDR; any other byte is discarded silently.
REQ-018 ADDR: an accepted byte latches addr_r and moves to DATA.
REQ-019 DATA: an accepted byte latches data_r and moves to CSUM (or to ISSUE per REQ-029).
REQ-020 CSUM: if (addr_r + data_r + byte) mod 256 == 0, move to ISSUE; otherwise report error code 2 and return to IDLE.
REQ-021 ISSUE: wr_valid=1 with wr_addr=addr_r and wr_data=data_r; stay until wr_ack, then go to IDLE with wr_valid=0 on the next cycle.
REQ-022 An accepted byte while in ISSUE reports error code 3 and is dropped; the pending write still completes.
REQ-023 Timeout counter clears on every accepted byte and on entry to ADDR; it counts in ADDR/DATA/CSUM.
REQ-024 When the counter reaches TIMEOUT_CYCLES-1, report error code 1 and go to IDLE.
REQ-025 Timeout and byte accept in the same cycle: the byte wins and no error is raised.
REQ-026 Error report: err_pulse=1 for one cycle, err_code updated, err_count+1 (saturates at 255).
REQ-027 wr_addr and wr_data are stable for the whole time wr_valid is high.

Reset
REQ-028 rst in any state: state=IDLE; wr_valid=0; wr_addr=0; wr_data=0; busy=0; err_pulse=0; err_code=0; err_count=0; timer=0; rx_ready edge register=1, so a byte already present is not re-accepted; a pending write is abandoned.

Configuration
REQ-029 With UART_CMD_CHECKSUM_EN defined: 4-byte frame (SYNC, ADDR, DATA, CSUM) per REQ-020.
- Without it: the CSUM state is not built, DATA goes directly to ISSUE, and err_code 2 never occurs.

Structure
REQ-030 The shared package holds the state encoding constants, the err_code constants (ERR_NONE, ERR_TIMEOUT, ERR_CSUM, ERR_OVERRUN) and the default SYNC_BYTE.
REQ-031 The timeout counter is a sub-module, uart_cmd_timer, with ports clk, rst, clear, enable and expired, parameterised by TIMEOUT_CYCLES.

Verification
REQ-032 Bytes A5,12,34,BA with checksum enabled -> wr_valid with wr_addr=12, wr_data=34; after wr_ack, state returns to IDLE and err_count=0.
REQ-033 Bytes A5,12,34,00 -> err_pulse once, err_code=2, err_count=1, no wr_valid.
REQ-034 Bytes A5,12, then silence longer than TIMEOUT_CYCLES (set to 100) -> err_code=1 exactly 100 cycles after the 12 accept; busy drops.
REQ-035 Valid frame with wr_ack held low, then extra byte 55 -> err_code=3; wr_valid stays high with 12/34 until wr_ack.
REQ-036 Bytes 00,FF, then A5,01,02,FD -> leading bytes ignored; write with addr 01, data 02; rst asserted mid-frame after A5 -> IDLE, all outputs 0.
REQ-037 rx_ready held high for 50 cycles on one byte -> exactly one accept.
